// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP register-file sizing, op latencies and decode helpers
package fpu_pkg;

  localparam int NREG      = 32;
  localparam int LAT_W     = 3;
  localparam int REG_IDX_W = 5;

  // Cycles from issue to writeback for each FP unit
  localparam int FADD_LAT  = 3;
  localparam int FMUL_LAT  = 4;
  localparam int FDIV_LAT  = 7;
  localparam int FSQRT_LAT = 6;

  typedef enum logic [2:0] {
    OP_FADD,
    OP_FMUL,
    OP_FDIV,
    OP_FSQRT,
    OP_FSTORE
  } fp_op_e;

  // Latency that decode drives onto issue_lat for a given op
  function automatic logic [LAT_W-1:0] op_lat(input fp_op_e op);
    case (op)
      OP_FADD:  op_lat = LAT_W'(FADD_LAT);
      OP_FMUL:  op_lat = LAT_W'(FMUL_LAT);
      OP_FDIV:  op_lat = LAT_W'(FDIV_LAT);
      OP_FSQRT: op_lat = LAT_W'(FSQRT_LAT);
      default:  op_lat = '0;
    endcase
  endfunction

  // Stores read FP registers but never write one
  function automatic logic op_writes_rd(input fp_op_e op);
    op_writes_rd = (op != OP_FSTORE);
  endfunction

endpackage

// File: rtl/fpu_sb_entry.sv
// rtl/fpu_sb_entry.sv - per-register writeback countdown with load, freeze and flush
module fpu_sb_entry
  import fpu_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         busy
);

  // Countdown: flush clears, freeze holds, a new issue reloads, otherwise drain to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - FP register scoreboard raising RAW/WAW hazards at decode
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int NREG     = fpu_pkg::NREG,
  parameter int LAT_W    = fpu_pkg::LAT_W,
  parameter int NSRC     = 3,
  parameter int FWD_DIST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*5-1:0]      src_idx,
  input  logic [NSRC-1:0]        src_use,
  input  logic                   issue_valid,
  input  logic                   issue_regwrite,
  input  logic [4:0]             issue_rd,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic                   freeze,
  input  logic                   flush,
  output logic                   hazard,
  output logic                   issue_fire,
  output logic [NREG-1:0]        busy
);

  localparam logic [LAT_W-1:0] FWD_CNT = LAT_W'(FWD_DIST);
  localparam int               IDX_SPAN = 1 << REG_IDX_W;

  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cnt_ext [IDX_SPAN];
  logic [NREG-1:0]  load;
  logic             load_en;
  logic             raw_hz;
  logic             waw_hz;

  // Indices beyond the tracked register count read as idle
  for (genvar r = 0; r < IDX_SPAN; r++) begin : g_ext
    if (r < NREG) begin : g_trk
      assign cnt_ext[r] = cnt[r];
    end else begin : g_idle
      assign cnt_ext[r] = '0;
    end
  end

  assign load_en = issue_fire & issue_regwrite & (issue_lat != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    assign load[r] = load_en & (issue_rd == REG_IDX_W'(r));

    fpu_sb_entry #(
      .W (LAT_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .freeze   (freeze),
      .flush    (flush),
      .load     (load[r]),
      .load_val (issue_lat),
      .cnt      (cnt[r]),
      .busy     (busy[r])
    );
  end

  // A used source whose producer is further out than the bypass window must wait
  always_comb begin
    raw_hz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_use[i] && (cnt_ext[src_idx[i*REG_IDX_W +: REG_IDX_W]] > FWD_CNT)) begin
        raw_hz = 1'b1;
      end
    end
  end

  // A new write must not land before an older in-flight write to the same register
  assign waw_hz = issue_regwrite & (cnt_ext[issue_rd] > issue_lat);

  assign hazard     = issue_valid & (raw_hz | waw_hz) & ~flush;
  assign issue_fire = issue_valid & ~hazard & ~freeze & ~flush;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb/tb_fpu_scoreboard.sv - scoreboard bench with a writeback-time reference model
module tb_fpu_scoreboard;
  import fpu_pkg::*;

  localparam int FWD = 1;

  typedef struct {
    logic        hz;
    logic        fire;
    logic [31:0] busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] src_idx = '0;
  logic [2:0]  src_use = '0;
  logic        issue_valid = 1'b0;
  logic        issue_regwrite = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [2:0]  issue_lat = '0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        hazard;
  logic        issue_fire;
  logic [31:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t expq[$];
  exp_t last;

  // Model: absolute writeback time per register on an "unfrozen cycles" timeline
  longint act = 0;
  longint ready_at [32];

  fpu_scoreboard #(
    .NREG (32), .LAT_W (3), .NSRC (3), .FWD_DIST (FWD)
  ) dut (
    .clk (clk), .rst (rst), .src_idx (src_idx), .src_use (src_use),
    .issue_valid (issue_valid), .issue_regwrite (issue_regwrite),
    .issue_rd (issue_rd), .issue_lat (issue_lat), .freeze (freeze),
    .flush (flush), .hazard (hazard), .issue_fire (issue_fire), .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic int rem(input int r);
    return (ready_at[r] > act) ? int'(ready_at[r] - act) : 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic raw, waw;
    raw = 1'b0;
    for (int i = 0; i < 3; i++)
      if (src_use[i] && rem(int'(src_idx[i*5 +: 5])) > FWD) raw = 1'b1;
    waw = issue_regwrite && (rem(int'(issue_rd)) > int'(issue_lat));
    e.hz   = issue_valid && (raw || waw) && !flush;
    e.fire = issue_valid && !e.hz && !freeze && !flush;
    for (int r = 0; r < 32; r++) e.busy[r] = (rem(r) != 0);
    return e;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
  endtask

  // Advance the model across a clock edge using the inputs held during the past cycle
  task automatic model_edge();
    if (rst || flush) begin
      model_clear();
    end else if (!freeze) begin
      if (last.fire && issue_regwrite && issue_lat != 0)
        ready_at[issue_rd] = act + 1 + longint'(issue_lat);
      act++;
    end
  endtask

  task automatic step(input logic v, input logic rw, input logic [4:0] rd, input logic [2:0] lat,
                      input logic [14:0] si, input logic [2:0] su, input logic fz, input logic fl);
    @(posedge clk);
    #1;
    model_edge();
    issue_valid = v; issue_regwrite = rw; issue_rd = rd; issue_lat = lat;
    src_idx = si; src_use = su; freeze = fz; flush = fl;
    if (rst) model_clear();
    last = predict();
    expq.push_back(last);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue_wr(input logic [4:0] rd, input logic [2:0] lat);
    step(1, 1, rd, lat, 0, 0, 0, 0);
  endtask

  // Present the same op until the model says it is accepted, bounded
  task automatic hold(input logic rw, input logic [4:0] rd, input logic [2:0] lat,
                      input logic [14:0] si, input logic [2:0] su);
    for (int k = 0; k < 12; k++) begin
      step(1, rw, rd, lat, si, su, 0, 0);
      if (last.fire) break;
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("hazard", {31'b0, hazard}, {31'b0, e.hz});
      check("issue_fire", {31'b0, issue_fire}, {31'b0, e.fire});
      check("busy", busy, e.busy);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    model_clear();
    last = '{hz: 1'b0, fire: 1'b0, busy: '0};

    // Reset with an op presented: accepted combinationally, nothing tracked
    step(1, 1, 5'd3, 3'd4, 0, 0, 0, 0);
    step(1, 0, 0, 0, {5'd0, 5'd0, 5'd3}, 3'b001, 0, 0);
    rst = 1'b0;

    // Dependent read right after a lat-4 producer
    idle(1);
    issue_wr(5'd3, 3'd4);
    hold(0, 0, 0, {5'd0, 5'd0, 5'd3}, 3'b001);
    idle(2);

    // Freeze holds a busy counter
    issue_wr(5'd5, 3'd4);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, {5'd0, 5'd0, 5'd5}, 3'b001, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    hold(0, 0, 0, {5'd5, 5'd0, 5'd0}, 3'b100);
    idle(3);

    // Write-after-write ordering on f7
    issue_wr(5'd7, 3'd5);
    hold(1, 5'd7, 3'd2, 0, 0);
    hold(0, 0, 0, {5'd0, 5'd7, 5'd0}, 3'b010);
    idle(3);

    // Flush with several busy registers and a concurrent issue
    issue_wr(5'd1, 3'd7);
    issue_wr(5'd2, 3'd7);
    issue_wr(5'd9, 3'd6);
    step(1, 1, 5'd12, 3'd3, 0, 0, 0, 1);
    step(1, 0, 0, 0, {5'd9, 5'd2, 5'd1}, 3'b111, 0, 0);
    idle(2);

    // Reload wins over the decrement in the same cycle
    issue_wr(5'd4, 3'd2);
    idle(1);
    issue_wr(5'd4, 3'd3);
    hold(0, 0, 0, {5'd0, 5'd0, 5'd4}, 3'b001);
    idle(1);

    // Latency zero never touches a counter
    issue_wr(5'd6, 3'd0);
    step(1, 0, 0, 0, {5'd0, 5'd0, 5'd6}, 3'b001, 0, 0);
    idle(1);

    // Mid-cycle asynchronous reset with four registers busy
    issue_wr(5'd10, 3'd7);
    issue_wr(5'd11, 3'd7);
    issue_wr(5'd12, 3'd7);
    issue_wr(5'd13, 3'd7);
    @(posedge clk);
    #1;
    model_edge();
    issue_valid = 1; issue_regwrite = 0; issue_rd = 0; issue_lat = 0;
    src_idx = {5'd0, 5'd0, 5'd10}; src_use = 3'b001; freeze = 0; flush = 0;
    #1;
    e = predict();
    check("pre_rst_hazard", {31'b0, hazard}, {31'b0, e.hz});
    check("pre_rst_busy", busy, e.busy);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 32'h0);
    check("async_rst_hazard", {31'b0, hazard}, 32'h0);
    model_clear();
    last = predict();
    expq.push_back(last);
    idle(1);
    rst = 1'b0;
    step(1, 1, 5'd10, 3'd2, {5'd11, 5'd12, 5'd10}, 3'b111, 0, 0);
    idle(3);

    // Randomized traffic through package-defined op latencies
    for (int n = 0; n < 600; n++) begin
      fp_op_e op;
      logic [2:0] lat;
      logic [14:0] si;
      op = fp_op_e'($urandom_range(0, 4));
      lat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : op_lat(op);
      for (int i = 0; i < 3; i++) si[i*5 +: 5] = 5'($urandom_range(0, 11));
      step($urandom_range(0, 9) < 7, op_writes_rd(op), 5'($urandom_range(0, 11)), lat, si,
           3'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end
    idle(2);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
